// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, flag bit positions, controller states.
package alu_pkg;

   localparam int OPW = 4;

   typedef enum logic [OPW-1:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_ADC    = 4'd2,
      OP_CMP    = 4'd3,
      OP_AND    = 4'd4,
      OP_OR     = 4'd5,
      OP_XOR    = 4'd6,
      OP_NOT    = 4'd7,
      OP_LSL    = 4'd8,
      OP_LSR    = 4'd9,
      OP_ASR    = 4'd10,
      OP_MUL    = 4'd11,
      OP_RSVD12 = 4'd12,
      OP_RSVD13 = 4'd13,
      OP_RSVD14 = 4'd14,
      OP_RSVD15 = 4'd15
   } op_e;

   localparam logic [OPW-1:0] OP_RSVD_LO = 4'd12;

   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, done pulses
// for one cycle once the down-counter reaches its terminal count.
module mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_busy;
   logic               r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= CW'(WIDTH);
            r_busy   <= 1'b1;
         end else if (r_busy) begin
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_prod;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU with persistent NZCV flags and a registered result slot.
//  state   | meaning
//  IDLE    | slot empty, ready to accept
//  EXEC    | single-cycle op computing from latched operands
//  MUL     | iterative multiply in progress
//  DONE    | result slot full, waiting for out_ready
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_err,
   output logic [3:0]       flags
);

   state_e             r_state;
   op_e                r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_res;
   logic               r_cin, r_err, r_valid;
   logic [3:0]         r_flags;

   logic               w_accept, w_acc_mul, w_finish;
   logic               w_mul_busy, w_mul_done, w_mul_fin;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_b_eff, w_fres, w_res;
   logic [WIDTH:0]     w_sum;
   logic               w_cin_eff, w_add_v, w_big_sh, w_c, w_v, w_err;

   assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign w_acc_mul = w_accept & (in_op == OP_MUL);
   assign w_mul_fin = w_mul_done & ~w_mul_busy;
   assign w_finish  = (r_state == ST_EXEC) | ((r_state == ST_MUL) & w_mul_fin);

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_acc_mul),
      .a       (in_a),
      .b       (in_b),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_prod)
   );

   // SUB/CMP share the adder as A + ~B + 1 so carry out means "no borrow"
   always_comb begin
      w_b_eff   = r_b;
      w_cin_eff = 1'b0;
      if (r_op == OP_SUB || r_op == OP_CMP) begin
         w_b_eff   = ~r_b;
         w_cin_eff = 1'b1;
      end else if (r_op == OP_ADC) begin
         w_cin_eff = r_cin;
      end
   end

   assign w_sum    = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
   assign w_add_v  = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != r_a[WIDTH-1]);
   assign w_big_sh = (r_b >= WIDTH'(WIDTH));

   always_comb begin
      w_fres = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_err  = 1'b0;
      if (r_state == ST_MUL) begin
         w_fres = w_prod[WIDTH-1:0];
         w_c    = |w_prod[2*WIDTH-1:WIDTH];
      end else begin
         case (r_op)
            OP_ADD, OP_SUB, OP_ADC, OP_CMP: begin
               w_fres = w_sum[WIDTH-1:0];
               w_c    = w_sum[WIDTH];
               w_v    = w_add_v;
            end
            OP_AND: w_fres = r_a & r_b;
            OP_OR:  w_fres = r_a | r_b;
            OP_XOR: w_fres = r_a ^ r_b;
            OP_NOT: w_fres = ~r_a;
            OP_LSL: w_fres = w_big_sh ? '0 : (r_a << r_b);
            OP_LSR: w_fres = w_big_sh ? '0 : (r_a >> r_b);
            OP_ASR: w_fres = w_big_sh ? {WIDTH{r_a[WIDTH-1]}} : WIDTH'($signed(r_a) >>> r_b);
            default: w_err = 1'b1;
         endcase
      end
      // CMP reports flags of the subtraction but passes A through untouched
      w_res = w_err ? '0 : ((r_op == OP_CMP) ? r_a : w_fres);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= OP_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_res   <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_flags <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= op_e'(in_op);
            r_a   <= in_a;
            r_b   <= in_b;
            r_cin <= r_flags[FLAG_C];
         end
         case (r_state)
            ST_IDLE: if (w_accept) r_state <= w_acc_mul ? ST_MUL : ST_EXEC;
            ST_EXEC: r_state <= ST_DONE;
            ST_MUL:  if (w_mul_fin) r_state <= ST_DONE;
            ST_DONE: if (out_ready) r_state <= w_accept ? (w_acc_mul ? ST_MUL : ST_EXEC) : ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         if (w_finish) begin
            r_valid <= 1'b1;
            r_res   <= w_res;
            r_err   <= w_err;
            if (!w_err) begin
               r_flags[FLAG_V] <= w_v;
               r_flags[FLAG_C] <= w_c;
               r_flags[FLAG_N] <= w_fres[WIDTH-1];
               r_flags[FLAG_Z] <= (w_fres == '0);
            end
         end else if (r_state == ST_DONE && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_result = r_res;
   assign out_err    = r_err;
   assign flags      = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed plan cases plus randomized ops against an
// integer-arithmetic reference model.
module tb_alu_mc;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = 4'd0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic         out_err;
   logic [3:0]   flags;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [3:0]   m_flags = 4'd0;

   alu_mc #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned/signed values of the operands.
   function automatic void model(input int op, input int a, input int b, input logic [3:0] fl,
                                 output logic [7:0] r, output logic [3:0] f, output logic e);
      int sa, sb, s, fr;
      logic c, v;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      c = 1'b0; v = 1'b0; e = 1'b0; fr = 0; s = 0;
      case (op)
         0: begin fr = a + b; c = (fr > 255); s = sa + sb; v = (s > 127) || (s < -128); end
         1, 3: begin fr = a - b; c = (a >= b); s = sa - sb; v = (s > 127) || (s < -128); end
         2: begin
            fr = a + b + int'(fl[2]); c = (fr > 255);
            s = sa + sb + int'(fl[2]); v = (s > 127) || (s < -128);
         end
         4: fr = a & b;
         5: fr = a | b;
         6: fr = a ^ b;
         7: fr = 255 - a;
         8: fr = (b >= 8) ? 0 : (a << b);
         9: fr = (b >= 8) ? 0 : (a >> b);
         10: fr = (b >= 8) ? ((sa < 0) ? 255 : 0) : (sa >>> b);
         11: begin fr = a * b; c = (fr > 255); end
         default: e = 1'b1;
      endcase
      fr = fr & 255;
      r = e ? 8'h00 : ((op == 3) ? 8'(a) : 8'(fr));
      f = e ? fl : {v, c, fr[7], (fr == 0)};
   endfunction

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk("issue_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 4'($urandom);
   endtask

   task automatic wait_valid(input int exp_lat);
      int n;
      n = 0;
      do begin
         @(negedge clk); n++;
         if (!out_valid) chk("busy_in_ready", 32'(in_ready), 32'd0);
      end while (!out_valid && n < 40);
      chk("latency", 32'(n), 32'(exp_lat));
   endtask

   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, output logic [7:0] o_res, output logic [3:0] o_fl,
                         output logic o_err);
      logic [7:0] er; logic [3:0] ef; logic ee;
      out_ready = 1'b0;
      issue(op, a, b);
      model(int'(op), int'(a), int'(b), m_flags, er, ef, ee);
      wait_valid((op == 4'd11) ? 10 : 2);
      chk("result", 32'(out_result), 32'(er));
      chk("flags", 32'(flags), 32'(ef));
      chk("err", 32'(out_err), 32'(ee));
      o_res = out_result; o_fl = flags; o_err = out_err;
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_result", 32'(out_result), 32'(er));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      m_flags = ef;
   endtask

   initial begin
      logic [7:0] r; logic [3:0] f; logic e;
      logic [7:0] er; logic [3:0] ef; logic ee;
      logic [3:0] op; logic [7:0] a, b;

      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(out_result), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run_op(4'd0, 8'h7F, 8'h01, 0, r, f, e);
      chk("tp_add_res", 32'(r), 32'h80);
      chk("tp_add_fl", 32'(f), 32'b1010);
      run_op(4'd1, 8'h05, 8'h05, 0, r, f, e);
      chk("tp_sub_fl", 32'(f), 32'b0101);
      run_op(4'd2, 8'h10, 8'h20, 1, r, f, e);
      chk("tp_adc_res", 32'(r), 32'h31);
      chk("tp_adc_fl", 32'(f), 32'b0000);
      run_op(4'd3, 8'h03, 8'h04, 0, r, f, e);
      chk("tp_cmp_res", 32'(r), 32'h03);
      chk("tp_cmp_fl", 32'(f), 32'b0010);
      run_op(4'd11, 8'h10, 8'h10, 0, r, f, e);
      chk("tp_mul1_fl", 32'(f), 32'b0101);
      run_op(4'd11, 8'h0F, 8'h03, 2, r, f, e);
      chk("tp_mul2_res", 32'(r), 32'h2D);
      run_op(4'd10, 8'h80, 8'd9, 0, r, f, e);
      chk("tp_asr_res", 32'(r), 32'hFF);
      run_op(4'd9, 8'h80, 8'd9, 0, r, f, e);
      chk("tp_lsr_res", 32'(r), 32'h00);
      run_op(4'd8, 8'h01, 8'd7, 0, r, f, e);
      chk("tp_lsl_res", 32'(r), 32'h80);
      run_op(4'd12, 8'h55, 8'h66, 0, r, f, e);
      chk("tp_rsvd_err", 32'(e), 32'd1);
      chk("tp_rsvd_fl", 32'(f), 32'b0010);

      // Backpressure then same-cycle drain + accept
      out_ready = 1'b0;
      issue(4'd0, 8'h01, 8'h02);
      model(0, 1, 2, m_flags, er, ef, ee);
      wait_valid(2);
      chk("bp_err_clr", 32'(out_err), 32'd0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_result", 32'(out_result), 32'h03);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      m_flags = ef;
      in_valid = 1'b1; in_op = 4'd6; in_a = 8'hF0; in_b = 8'hFF; out_ready = 1'b1;
      #1;
      chk("bp_drain_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      model(6, 8'hF0, 8'hFF, m_flags, er, ef, ee);
      wait_valid(2);
      chk("bp_xor_res", 32'(out_result), 32'h0F);
      chk("bp_xor_fl", 32'(flags), 32'(ef));
      m_flags = ef;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset during multiply
      issue(4'd11, 8'h0F, 8'h03);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_flags", 32'(flags), 32'd0);
      chk("mrst_result", 32'(out_result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      repeat (14) begin
         @(negedge clk);
         chk("mrst_no_stale", 32'(out_valid), 32'd0);
      end
      m_flags = 4'd0;

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = (op >= 4'd8 && op <= 4'd10) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 255));
         run_op(op, a, b, $urandom_range(0, 3), r, f, e);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, handshaked successor to the combinational datapath ALU.
- Widens the opcode space to AND/OR/XOR/NOT, three shifts, add-with-carry, compare, and an iterative unsigned multiply.
- Holds a persistent NZCV flag register and a registered result slot with valid/ready on both sides.
- Sits between the instruction sequencer (producer) and register-file writeback (consumer).

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- OPW, 4, opcode width; fixed by alu_pkg.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has an operation
- in_ready  out  1  block can accept this cycle
- in_op  in  OPW  opcode (alu_pkg encoding)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B / shift amount
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  registered result
- out_err  out  1  reserved opcode was executed
- flags  out  4  registered {V,C,N,Z}

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, out_valid=0, out_result=0, out_err=0, flags=0, multiplier cleared. Reset mid-MUL aborts; no partial result is ever presented.
- States:
  - IDLE -> EXEC on accept of a single-cycle op; -> MUL on accept of MUL.
  - EXEC -> DONE (1 cycle).
  - MUL -> DONE after WIDTH iterations.
  - DONE -> IDLE on out_ready without new accept; DONE -> EXEC/MUL on same-cycle drain+accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; operands and op latched on accept.
- Latency, accept edge to out_valid: 2 cycles for single-cycle ops; WIDTH+2 cycles for MUL. Back-to-back single-cycle throughput is one op per 2 cycles.
- out_valid holds, and out_result/out_err stay stable, until out_ready. No drop under backpressure.
- Flags update exactly once, on the cycle entering DONE:
  - N = result[WIDTH-1]; Z = (result==0).
- Opcodes:
  - 0 ADD: A+B. C = carry out; V = signed overflow (operand signs equal, result sign differs).
  - 1 SUB: A+~B+1. C = carry out (1 = no borrow); V as for A-B.
  - 2 ADC: A+B+flags.C, using flags.C as held at accept. C, V as ADD.
  - 3 CMP: flags as SUB; out_result = A unchanged.
  - 4 AND, 5 OR, 6 XOR, 7 NOT A: C=0, V=0.
  - 8 LSL, 9 LSR, 10 ASR: shift amount is all of B.
    - B>=WIDTH gives 0 for LSL/LSR and WIDTH copies of A's sign for ASR.
    - C=0, V=0.
  - 11 MUL: unsigned shift-add, one partial product per cycle. out_result = low WIDTH bits; C = |high WIDTH bits; V=0.
  - 12-15 reserved: out_result=0, out_err=1, flags unchanged.
- out_err clears on the next completed valid op.
- in_* ignored when no accept occurs. in_valid may drop without completing.

Decomposition:
- alu_pkg:
  - opcode enum (OP_ADD..OP_MUL, OP_RSVD range)
  - flag index constants FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0
  - state enum {IDLE, EXEC, MUL, DONE}
- Sub-module mul_iter #(WIDTH):
  - ports: start, a, b → busy, done, product[2*WIDTH-1:0]
  - counter $clog2(WIDTH)+1 bits
  - same clk/rst_n

Test Plan (WIDTH=8):
- ADD 0x7F+0x01, out_ready=1 → out_result=0x80, flags=4'b1010, out_valid exactly 2 cycles after accept, in_ready=0 while EXEC.
- SUB 0x05-0x05 then ADC 0x10+0x20 → first 0x00 flags=4'b0101; ADC uses C=1 → 0x31 flags=4'b0000; CMP 0x03,0x04 → out_result=0x03, flags=4'b0010.
- MUL 0x10*0x10 → out_result=0x00, flags=4'b0101, out_valid 10 cycles after accept; MUL 0x0F*0x03 → 0x2D, flags=4'b0000.
- Backpressure: ADD 1+2, hold out_ready=0 5 cycles → out_result=0x03 stable, in_ready=0; then out_ready=1 with in_valid=1 (XOR 0xF0^0xFF) → same-cycle drain+accept, next result 0x0F.
- Shifts/reserved: ASR 0x80 by 9 → 0xFF; LSR 0x80 by 9 → 0x00; LSL 0x01 by 7 → 0x80; op 12 → out_err=1, out_result=0, flags unchanged.
- Reset mid-MUL: rst_n low at iteration 3 → immediately out_valid=0, flags=0, in_ready=1 after release; no stale result appears.
